// File: rtl/mf_sequencer_pkg.sv
// Shared types and constants for the matched-filter sequencer.
package mf_sequencer_pkg;

    localparam int unsigned MF_TAPS  = 127;
    localparam int unsigned MF_DRAIN = 3;
    localparam int unsigned OFS_W    = 7;
    localparam int unsigned SAMPLE_W = 8;
    localparam int unsigned COEFF_W  = 8;
    localparam int unsigned RESULT_W = 16;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned DRAIN_W  = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_PREFETCH = 3'd2,
        ST_RUN      = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic [COEFF_W-1:0]  coeff_t;
    typedef logic [RESULT_W-1:0] result_t;
    typedef logic [OFS_W-1:0]    ofs_t;
    typedef logic [CNT_W-1:0]    cnt_t;

    // Increment that sticks at lim instead of wrapping.
    function automatic ofs_t sat_inc(ofs_t v, ofs_t lim);
        return (v >= lim) ? lim : v + ofs_t'(1);
    endfunction

endpackage

// File: rtl/mf_sequencer_if.sv
// Sample, coefficient-ROM and filter-side signals of the sequencer.
interface mf_sequencer_if;
    import mf_sequencer_pkg::*;

    logic    sample_valid;
    sample_t sample_in;
    ofs_t    coeff_addr;
    coeff_t  coeff_data;
    logic    mf_ready;
    sample_t mf_x;
    ofs_t    mf_offset;
    ofs_t    mf_index;
    coeff_t  mf_coeff;
    result_t mf_y;
    logic    y_valid;
    result_t y_out;
    logic    busy;
    cnt_t    overrun_cnt;

    modport master (
        input  sample_valid, sample_in, coeff_data, mf_y,
        output coeff_addr, mf_ready, mf_x, mf_offset, mf_index, mf_coeff,
               y_valid, y_out, busy, overrun_cnt
    );

    modport slave (
        output sample_valid, sample_in, coeff_data, mf_y,
        input  coeff_addr, mf_ready, mf_x, mf_offset, mf_index, mf_coeff,
               y_valid, y_out, busy, overrun_cnt
    );

endinterface

// File: rtl/mf_sequencer_pending_buf.sv
// One-entry holding register for a sample that arrives while a pass is running.
module mf_pending_buf
    import mf_sequencer_pkg::*;
(
    input  logic    clock,
    input  logic    rst_n,
    input  logic    push_i,
    input  logic    pop_i,
    input  sample_t data_i,
    output logic    full_o,
    output sample_t data_o,
    output logic    drop_c
);

    logic    full_q, full_d;
    sample_t data_q, data_d;

    // Simultaneous pop and push replaces the entry and keeps it full.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (pop_i) begin
            full_d = 1'b0;
        end
        if (push_i && (!full_q || pop_i)) begin
            full_d = 1'b1;
            data_d = data_i;
        end
    end

    assign drop_c = push_i & full_q & ~pop_i;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/mf_sequencer.sv
// Per-sample controller for the 127-tap matched filter: load, step taps, drain, capture.
module mf_sequencer
    import mf_sequencer_pkg::*;
#(
    parameter int unsigned TAPS         = MF_TAPS,
    parameter int unsigned DRAIN_CYCLES = MF_DRAIN
) (
    input  logic           clock,
    input  logic           reset_n,
    mf_sequencer_if.master bus
);

    localparam ofs_t               IDX_END    = OFS_W'(TAPS);
    localparam ofs_t               IDX_LAST   = OFS_W'(TAPS - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    // Reset asserts asynchronously, releases two clocks later.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n_s;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_n_s    = rst_sync_q[1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    state_t             state_q, state_d;
    logic               mf_ready_q, mf_ready_d;
    sample_t            mf_x_q, mf_x_d;
    ofs_t               mf_offset_q, mf_offset_d;
    ofs_t               mf_index_q, mf_index_d;
    ofs_t               coeff_addr_q, coeff_addr_d;
    coeff_t             mf_coeff_q, mf_coeff_d;
    logic               y_valid_q, y_valid_d;
    result_t            y_out_q, y_out_d;
    logic               busy_q, busy_d;
    cnt_t               overrun_q, overrun_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;

    logic    pend_push, pend_pop, pend_full, pend_drop_c;
    sample_t pend_data;

    mf_pending_buf u_pending (
        .clock  (clock),
        .rst_n  (rst_n_s),
        .push_i (pend_push),
        .pop_i  (pend_pop),
        .data_i (bus.sample_in),
        .full_o (pend_full),
        .data_o (pend_data),
        .drop_c (pend_drop_c)
    );

    // ROM address runs one tap ahead of mf_index so mf_coeff lands aligned with it.
    always_comb begin
        state_d      = state_q;
        mf_ready_d   = 1'b0;
        mf_x_d       = mf_x_q;
        mf_offset_d  = mf_offset_q;
        mf_index_d   = IDX_END;
        coeff_addr_d = coeff_addr_q;
        mf_coeff_d   = mf_coeff_q;
        y_valid_d    = 1'b0;
        y_out_d      = y_out_q;
        drain_cnt_d  = drain_cnt_q;
        pend_push    = 1'b0;
        pend_pop     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pend_full || bus.sample_valid) begin
                    state_d      = ST_LOAD;
                    mf_ready_d   = 1'b1;
                    coeff_addr_d = '0;
                    mf_x_d       = pend_full ? pend_data : bus.sample_in;
                    pend_pop     = pend_full;
                    pend_push    = pend_full & bus.sample_valid;
                end
            end
            ST_LOAD: begin
                state_d      = ST_PREFETCH;
                coeff_addr_d = ofs_t'(1);
            end
            ST_PREFETCH: begin
                state_d      = ST_RUN;
                mf_index_d   = '0;
                mf_coeff_d   = bus.coeff_data;
                coeff_addr_d = sat_inc(coeff_addr_q, IDX_LAST);
            end
            ST_RUN: begin
                if (mf_index_q == IDX_LAST) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end else begin
                    mf_index_d   = mf_index_q + ofs_t'(1);
                    mf_coeff_d   = bus.coeff_data;
                    coeff_addr_d = sat_inc(coeff_addr_q, IDX_LAST);
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                y_out_d     = bus.mf_y;
                y_valid_d   = 1'b1;
                mf_offset_d = mf_offset_q + ofs_t'(1);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_q != ST_IDLE) begin
            pend_push = bus.sample_valid;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // Saturating drop counter.
    always_comb begin
        overrun_d = overrun_q;
        if (pend_drop_c && (overrun_q != '1)) begin
            overrun_d = overrun_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q      <= ST_IDLE;
            mf_ready_q   <= 1'b0;
            mf_x_q       <= '0;
            mf_offset_q  <= '0;
            mf_index_q   <= IDX_END;
            coeff_addr_q <= '0;
            mf_coeff_q   <= '0;
            y_valid_q    <= 1'b0;
            y_out_q      <= '0;
            busy_q       <= 1'b0;
            overrun_q    <= '0;
            drain_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            mf_ready_q   <= mf_ready_d;
            mf_x_q       <= mf_x_d;
            mf_offset_q  <= mf_offset_d;
            mf_index_q   <= mf_index_d;
            coeff_addr_q <= coeff_addr_d;
            mf_coeff_q   <= mf_coeff_d;
            y_valid_q    <= y_valid_d;
            y_out_q      <= y_out_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            drain_cnt_q  <= drain_cnt_d;
        end
    end

    assign bus.coeff_addr  = coeff_addr_q;
    assign bus.mf_ready    = mf_ready_q;
    assign bus.mf_x        = mf_x_q;
    assign bus.mf_offset   = mf_offset_q;
    assign bus.mf_index    = mf_index_q;
    assign bus.mf_coeff    = mf_coeff_q;
    assign bus.y_valid     = y_valid_q;
    assign bus.y_out       = y_out_q;
    assign bus.busy        = busy_q;
    assign bus.overrun_cnt = overrun_q;

endmodule

// File: tb/tb_mf_sequencer.sv
// Scoreboard bench for mf_sequencer with a behavioural ROM and accumulating filter.
module tb_mf_sequencer;
    import mf_sequencer_pkg::*;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    mf_sequencer_if bus ();

    mf_sequencer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    typedef struct { logic [7:0] x; logic [6:0] off; int gap; } rdy_exp_t;
    typedef struct { logic [15:0] y; int t0; bit lat; } y_exp_t;

    rdy_exp_t   rdy_q[$];
    y_exp_t     y_q[$];
    int         total    = 0;
    int         bad      = 0;
    int         cyc      = 0;
    int         last_rdy = 0;
    bit         sb_en    = 1'b1;
    logic [6:0] exp_off  = '0;
    logic [6:0] prev_idx = 7'd127;

    function automatic logic [7:0] rom_f(logic [6:0] a);
        logic [7:0] t;
        t = {1'b0, a} * 8'd37 + 8'd11;
        return t ^ 8'h5A;
    endfunction

    function automatic logic [15:0] prod(logic [7:0] xv, logic [7:0] cv);
        logic signed [15:0] xs, cs;
        xs = {{8{xv[7]}}, xv};
        cs = {{8{cv[7]}}, cv};
        return 16'(xs * cs);
    endfunction

    function automatic logic [15:0] exp_y(logic [7:0] xv, logic [6:0] off);
        logic [15:0] s;
        s = '0;
        for (int k = 0; k < 127; k++) s = s + prod(xv, rom_f(7'(k)));
        return s + {9'd0, off};
    endfunction

    // Synchronous coefficient ROM and a stand-in filter that sums x*coeff over valid taps.
    logic [15:0] acc  = '0;
    logic [6:0]  loff = '0;

    always @(posedge clock) bus.coeff_data <= rom_f(bus.coeff_addr);

    always @(posedge clock) begin
        if (bus.mf_ready) begin
            acc  <= '0;
            loff <= bus.mf_offset;
        end else if (bus.mf_index < 7'd127) begin
            acc <= acc + prod(bus.mf_x, bus.mf_coeff);
        end
    end

    assign bus.mf_y = acc + {9'd0, loff};

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(string name);
        total++;
        bad++;
        $display("FAIL %s: event not expected or not reached at cycle %0d", name, cyc);
    endtask

    // Monitor: pops expectations whenever the DUT strobes, checks tap alignment every cycle.
    always @(negedge clock) begin : monitor
        rdy_exp_t re;
        y_exp_t   ye;
        if (bus.mf_index != 7'd127) begin
            chk("coeff_align", 32'(bus.mf_coeff), 32'(rom_f(bus.mf_index)));
            chk("index_step", 32'(bus.mf_index), (prev_idx == 7'd127) ? 32'd0 : 32'(prev_idx) + 32'd1);
        end
        prev_idx = bus.mf_index;
        if (sb_en && bus.mf_ready) begin
            if (rdy_q.size() == 0) begin
                fail_now("ready_unexpected");
            end else begin
                re = rdy_q.pop_front();
                chk("ready_x", 32'(bus.mf_x), 32'(re.x));
                chk("ready_offset", 32'(bus.mf_offset), 32'(re.off));
                if (re.gap != 0) chk("ready_gap", 32'(cyc - last_rdy), 32'(re.gap));
            end
            last_rdy = cyc;
        end
        if (sb_en && bus.y_valid) begin
            if (y_q.size() == 0) begin
                fail_now("y_valid_unexpected");
            end else begin
                ye = y_q.pop_front();
                chk("y_out", 32'(bus.y_out), 32'(ye.y));
                if (ye.lat) chk("latency", 32'(cyc - ye.t0), 32'd133);
            end
        end
    end

    task automatic strobe(logic [7:0] xv, bit accept, int gap, bit lat);
        @(negedge clock);
        if (accept) begin
            rdy_q.push_back('{x: xv, off: exp_off, gap: gap});
            y_q.push_back('{y: exp_y(xv, exp_off), t0: cyc + 1, lat: lat});
            exp_off = exp_off + 7'd1;
        end
        bus.sample_valid = 1'b1;
        bus.sample_in    = xv;
        @(negedge clock);
        bus.sample_valid = 1'b0;
    endtask

    task automatic wait_idle(string name);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while ((bus.busy || rdy_q.size() != 0 || y_q.size() != 0) && n < 3000);
        if (n >= 3000) fail_now(name);
    endtask

    task automatic chk_rst(string tag);
        chk({tag, "_mf_ready"},   32'(bus.mf_ready),    32'd0);
        chk({tag, "_mf_x"},       32'(bus.mf_x),        32'd0);
        chk({tag, "_mf_offset"},  32'(bus.mf_offset),   32'd0);
        chk({tag, "_mf_index"},   32'(bus.mf_index),    32'd127);
        chk({tag, "_coeff_addr"}, 32'(bus.coeff_addr),  32'd0);
        chk({tag, "_mf_coeff"},   32'(bus.mf_coeff),    32'd0);
        chk({tag, "_y_valid"},    32'(bus.y_valid),     32'd0);
        chk({tag, "_y_out"},      32'(bus.y_out),       32'd0);
        chk({tag, "_busy"},       32'(bus.busy),        32'd0);
        chk({tag, "_overrun"},    32'(bus.overrun_cnt), 32'd0);
    endtask

    // Called at a falling edge; reset takes effect at once.
    task automatic do_reset(string tag);
        reset_n = 1'b0;
        #1;
        chk_rst(tag);
        rdy_q.delete();
        y_q.delete();
        exp_off = '0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    initial begin
        int n;
        bus.sample_valid = 1'b0;
        bus.sample_in    = '0;
        #2 reset_n = 1'b0;
        @(negedge clock);
        chk_rst("por");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);

        // Single sample
        strobe(8'd5, 1'b1, 0, 1'b1);
        wait_idle("t1_idle_timeout");
        chk("t1_offset", 32'(bus.mf_offset), 32'd1);
        chk("t1_overrun", 32'(bus.overrun_cnt), 32'd0);

        // Second sample held in pending during a pass
        @(negedge clock);
        do_reset("t2_rst");
        strobe(8'd7, 1'b1, 0, 1'b1);
        repeat (20) @(negedge clock);
        strobe(8'd253, 1'b1, 134, 1'b0);
        wait_idle("t2_idle_timeout");
        chk("t2_offset", 32'(bus.mf_offset), 32'd2);
        chk("t2_overrun", 32'(bus.overrun_cnt), 32'd0);

        // Third strobe in one pass is dropped
        strobe(8'd1, 1'b1, 0, 1'b1);
        repeat (10) @(negedge clock);
        strobe(8'd2, 1'b1, 134, 1'b0);
        repeat (10) @(negedge clock);
        strobe(8'd3, 1'b0, 0, 1'b0);
        wait_idle("t3_idle_timeout");
        chk("t3_overrun", 32'(bus.overrun_cnt), 32'd1);
        chk("t3_offset", 32'(bus.mf_offset), 32'd4);

        // Continuous strobes for 300 cycles saturate the drop counter
        sb_en = 1'b0;
        @(negedge clock);
        bus.sample_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bus.sample_in = 8'(i);
            @(negedge clock);
        end
        bus.sample_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 2000 && n < 3; i++) begin
            @(negedge clock);
            n = bus.busy ? 0 : n + 1;
        end
        if (n < 3) fail_now("sat_idle_timeout");
        chk("sat_overrun", 32'(bus.overrun_cnt), 32'd255);
        do_reset("sat_rst");
        sb_en = 1'b1;

        // 130 passes: offset wraps 127 -> 0
        for (int i = 0; i < 130; i++) begin
            strobe(8'(i * 7 + 3), 1'b1, 0, 1'b0);
            wait_idle("t4_idle_timeout");
        end
        chk("t4_offset", 32'(bus.mf_offset), 32'd2);

        // Reset in the middle of a pass
        strobe(8'd9, 1'b1, 0, 1'b0);
        n = 0;
        while (bus.mf_index != 7'd60 && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (n >= 300) fail_now("t5_index60_timeout");
        do_reset("t5_rst");
        repeat (200) @(negedge clock);
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_offset_held", 32'(bus.mf_offset), 32'd0);
        strobe(8'd4, 1'b1, 0, 1'b1);
        wait_idle("t5_idle_timeout");
        chk("t5_offset", 32'(bus.mf_offset), 32'd1);

        // Long idle
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            chk("t6_idle", {22'd0, bus.mf_index, bus.mf_ready, bus.y_valid, bus.busy},
                {22'd0, 7'd127, 3'b000});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
